// File: rtl/serial_add_ctrl.sv
// Parallel-side controller for a bit-serial adder: loads operands, streams them LSB-first,
// collects the serial sum and carry-out. Define SERADD_OVERFLOW_EN to enable the signed-overflow flag.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ser_clr,
  output logic             ser_x,
  output logic             ser_y,
  input  logic             ser_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(WIDTH);
`ifdef SERADD_OVERFLOW_EN
  localparam logic [CNT_W-1:0] MSB_K  = CNT_W'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERADD_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  // Control and result state; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERADD_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERADD_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // NOTE: operand shift registers carry no reset; they are always reloaded on acceptance
  // before any bit of them reaches the adder.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
`ifdef SERADD_OVERFLOW_EN
    ovf_d     = ovf_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    ser_clr   = 1'b0;
    ser_x     = 1'b0;
    ser_y     = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        ser_clr  = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        ser_clr = 1'b1;
        cnt_d   = '0;
        state_d = SHIFT;
      end

      SHIFT: begin
        if (cnt_q == LAST_K) begin
          // With x=y=0 the adder's sum bit is its stored carry.
          cout_d  = ser_s;
          state_d = DONE;
        end else begin
          ser_x = a_q[0];
          ser_y = b_q[0];
          a_d   = a_q >> 1;
          b_d   = b_q >> 1;
          sum_d = {ser_s, sum_q[WIDTH-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
`ifdef SERADD_OVERFLOW_EN
          if (cnt_q == MSB_K) begin
            ovf_d = (ser_x == ser_y) && (ser_s != ser_x);
          end
`endif
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERADD_OVERFLOW_EN
  assign ovf  = ovf_q;
`else
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: behavioural serial adder, vector table, scoreboard,
// plus hand-written reset-in-flight sequence. Honours SERADD_OVERFLOW_EN for ovf expectations.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic             in_ready, ser_clr, ser_x, ser_y, ser_s, out_valid, cout, ovf;
  logic [WIDTH-1:0] sum;

  int n_checks = 0;
  int n_errors = 0;
  int overlap_cnt = 0;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } result_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
    int         hold;
    bit         keep_valid;
  } vec_t;

  result_t sb_q[$];
  vec_t    vecs[8];

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ser_clr   (ser_clr),
    .ser_x     (ser_x),
    .ser_y     (ser_y),
    .ser_s     (ser_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Behavioural bit-serial adder: carry cleared while ser_clr is high.
  logic carry_q = 1'b0;
  always @(posedge clk) begin
    if (ser_clr) carry_q <= 1'b0;
    else         carry_q <= (ser_x & ser_y) | (ser_x & carry_q) | (ser_y & carry_q);
  end
  assign ser_s = ser_x ^ ser_y ^ carry_q;

  always @(negedge clk) begin
    if (in_ready && out_valid) overlap_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic exp_ovf(input logic [7:0] av, input logic [7:0] bv);
`ifdef SERADD_OVERFLOW_EN
    logic [7:0] s;
    s = av + bv;
    return (av[7] == bv[7]) && (s[7] != av[7]);
`else
    return 1'b0;
`endif
  endfunction

  // Starts and ends just after a falling edge.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] es, input logic ec, input int hold, input bit keep_valid);
    int      n;
    int      lat;
    int      clr_bad;
    int      bad;
    logic [8:0] xs;
    logic [8:0] ys;
    result_t r;

    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_in_ready", tag), in_ready, 1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk);
    sb_q.push_back('{sum: es, cout: ec, ovf: exp_ovf(av, bv)});
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);

    lat = 0;
    xs = '0;
    ys = '0;
    clr_bad = 0;
    check($sformatf("%s_clear_clr", tag), ser_clr, 1);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!out_valid && lat <= WIDTH + 1) begin
        xs[lat-1] = ser_x;
        ys[lat-1] = ser_y;
        if (ser_clr) clr_bad++;
      end
    end
    in_valid = 1'b0;
    check($sformatf("%s_latency", tag), lat, WIDTH + 2);
    check($sformatf("%s_ser_x", tag), xs, {1'b0, av});
    check($sformatf("%s_ser_y", tag), ys, {1'b0, bv});
    check($sformatf("%s_clr_in_shift", tag), clr_bad, 0);

    if (out_valid) begin
      check($sformatf("%s_sb_depth", tag), sb_q.size(), 1);
      if (sb_q.size() > 0) begin
        r = sb_q.pop_front();
        check($sformatf("%s_sum", tag), sum, r.sum);
        check($sformatf("%s_cout", tag), cout, r.cout);
        check($sformatf("%s_ovf", tag), ovf, r.ovf);
        bad = 0;
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          if (!out_valid || in_ready || sum !== r.sum || cout !== r.cout || ovf !== r.ovf) bad++;
        end
        if (hold > 0) check($sformatf("%s_hold_stable", tag), bad, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check($sformatf("%s_released", tag), {out_valid, in_ready}, 2'b01);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: 8'h05, b: 8'h03, sum: 8'h08, cout: 1'b0, hold: 0,  keep_valid: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, cout: 1'b1, hold: 0,  keep_valid: 1'b0};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE, cout: 1'b1, hold: 0,  keep_valid: 1'b0};
    vecs[3] = '{a: 8'h00, b: 8'h00, sum: 8'h00, cout: 1'b0, hold: 0,  keep_valid: 1'b0};
    vecs[4] = '{a: 8'h12, b: 8'h34, sum: 8'h46, cout: 1'b0, hold: 20, keep_valid: 1'b0};
    vecs[5] = '{a: 8'h7F, b: 8'h01, sum: 8'h80, cout: 1'b0, hold: 0,  keep_valid: 1'b0};
    vecs[6] = '{a: 8'h80, b: 8'h80, sum: 8'h00, cout: 1'b1, hold: 3,  keep_valid: 1'b1};
    vecs[7] = '{a: 8'hA5, b: 8'h5A, sum: 8'hFF, cout: 1'b0, hold: 0,  keep_valid: 1'b1};

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_ser_clr", ser_clr, 1);
    check("rst_ser_xy", {ser_x, ser_y}, 2'b00);
    check("rst_sum", sum, 8'h00);
    check("rst_cout_ovf", {cout, ovf}, 2'b00);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout,
             vecs[i].hold, vecs[i].keep_valid);
    end

    // Reset in the middle of SHIFT (k=4) of 0xAA+0x55; no result may appear.
    a = 8'hAA;
    b = 8'h55;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_shift_clr", ser_clr, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 8'h00);
    check("midrst_cout_ovf", {cout, ovf}, 2'b00);
    check("midrst_ser_clr", ser_clr, 1);
    begin
      int seen;
      seen = 0;
      repeat (14) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("midrst_no_result", seen, 0);
    end
    run_op("post_rst", 8'h01, 8'h01, 8'h02, 1'b0, 0, 1'b0);

    check("handshake_overlap", overlap_cnt, 0);
    check("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
